// File: rtl/output_frame_ctrl.sv
// Output bank frame sequencer: steps through SLOTS header/payload read slots,
// clears the read bank in a guard window, and swaps banks at each RUN frame end.
module output_frame_ctrl #(
  parameter int unsigned SLOTS    = 4,
  parameter int unsigned HALF_CYC = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  output logic                     bank_sel,
  output logic                     bank2_sel,
  output logic                     mem_clr,
  output logic [$clog2(SLOTS)-1:0] running2_slot,
  output logic                     header2_present,
  output logic                     primeup,
  output logic                     frame_start
);

  localparam int unsigned SW    = $clog2(SLOTS);
  localparam int unsigned HW    = $clog2(HALF_CYC);
  localparam int unsigned RW    = SLOTS * 2 * HALF_CYC;
  localparam int unsigned FRAME = RW + SLOTS;
  localparam int unsigned CW    = $clog2(FRAME);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic            bank_q, bank_d;
  logic            clr_q, clr_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic            hdr_q, hdr_d;
  logic            prime_q, prime_d;
  logic            fs_q, fs_d;

  logic last_c, rd_end_c, half_end_c;

  assign last_c     = (cnt_q == CW'(FRAME - 1));
  assign rd_end_c   = (cnt_q == CW'(RW - 1));
  assign half_end_c = (hcnt_q == HW'(HALF_CYC - 1));

  // Next-state values; every output register is loaded from its _d here.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hcnt_d  = hcnt_q;
    bank_d  = bank_q;
    clr_d   = clr_q;
    slot_d  = slot_q;
    hdr_d   = hdr_q;
    prime_d = prime_q;
    fs_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d = FILL;
          cnt_d   = '0;
          hcnt_d  = '0;
          bank_d  = 1'b0;
          clr_d   = 1'b0;
          slot_d  = '0;
          hdr_d   = 1'b0;
          prime_d = 1'b0;
          fs_d    = 1'b1;
        end
      end
      FILL, RUN: begin
        if (last_c) begin
          cnt_d  = '0;
          hcnt_d = '0;
          clr_d  = 1'b0;
          slot_d = '0;
          hdr_d  = 1'b0;
          if (state_q == FILL || en) begin
            state_d = RUN;
            prime_d = 1'b1;
            fs_d    = 1'b1;
            // The fill frame only preloads; banks swap at RUN frame ends.
            bank_d  = (state_q == RUN) ? ~bank_q : bank_q;
          end else begin
            state_d = IDLE;
            prime_d = 1'b0;
            bank_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (rd_end_c) begin
            clr_d  = 1'b1;
            slot_d = '0;
            hdr_d  = 1'b0;
            hcnt_d = '0;
          end else if (!clr_q) begin
            if (half_end_c) begin
              hcnt_d = '0;
              if (hdr_q) begin
                hdr_d  = 1'b0;
                slot_d = slot_q + SW'(1);
              end else begin
                hdr_d = 1'b1;
              end
            end else begin
              hcnt_d = hcnt_q + HW'(1);
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        hcnt_d  = '0;
        bank_d  = 1'b0;
        clr_d   = 1'b0;
        slot_d  = '0;
        hdr_d   = 1'b0;
        prime_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hcnt_q  <= '0;
      bank_q  <= 1'b0;
      clr_q   <= 1'b0;
      slot_q  <= '0;
      hdr_q   <= 1'b0;
      prime_q <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hcnt_q  <= hcnt_d;
      bank_q  <= bank_d;
      clr_q   <= clr_d;
      slot_q  <= slot_d;
      hdr_q   <= hdr_d;
      prime_q <= prime_d;
      fs_q    <= fs_d;
    end
  end

  assign bank_sel        = bank_q;
  assign bank2_sel       = bank_q;
  assign mem_clr         = clr_q;
  assign running2_slot   = slot_q;
  assign header2_present = hdr_q;
  assign primeup         = prime_q;
  assign frame_start     = fs_q;

endmodule

// File: tb/tb_output_frame_ctrl.sv
// Directed bench for output_frame_ctrl: default build (4 slots x 10) and a
// small build (2 slots x 2), with expected outputs derived from frame cycle.
module tb_output_frame_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, en0, rst1, en1;
  logic       bs0, b2s0, clr0, hdr0, pu0, fs0;
  logic [1:0] slot0;
  logic       bs1, b2s1, clr1, hdr1, pu1, fs1;
  logic [0:0] slot1;

  int vectors     = 0;
  int miscompares = 0;

  output_frame_ctrl #(.SLOTS(4), .HALF_CYC(10)) dut0 (
    .clk(clk), .rst(rst0), .en(en0),
    .bank_sel(bs0), .bank2_sel(b2s0), .mem_clr(clr0),
    .running2_slot(slot0), .header2_present(hdr0),
    .primeup(pu0), .frame_start(fs0)
  );

  output_frame_ctrl #(.SLOTS(2), .HALF_CYC(2)) dut1 (
    .clk(clk), .rst(rst1), .en(en1),
    .bank_sel(bs1), .bank2_sel(b2s1), .mem_clr(clr1),
    .running2_slot(slot1), .header2_present(hdr1),
    .primeup(pu1), .frame_start(fs1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Structural invariants, sampled every cycle away from the rising edge.
  always @(negedge clk) begin
    chk("inv0 bank eq", 32'(bs0), 32'(b2s0));
    chk("inv1 bank eq", 32'(bs1), 32'(b2s1));
    chk("inv0 slot range", 32'(slot0 < 2'd3 || slot0 == 2'd3), 32'd1);
    chk("inv0 clr guard", 32'(!clr0 || (slot0 == 2'd0 && !hdr0)), 32'd1);
    chk("inv1 clr guard", 32'(!clr1 || (slot1 == 1'b0 && !hdr1)), 32'd1);
  end

  task automatic sample(input int d, output logic [31:0] o[7]);
    if (d == 0) begin
      o[0] = 32'(bs0); o[1] = 32'(b2s0); o[2] = 32'(clr0); o[3] = 32'(slot0);
      o[4] = 32'(hdr0); o[5] = 32'(pu0); o[6] = 32'(fs0);
    end else begin
      o[0] = 32'(bs1); o[1] = 32'(b2s1); o[2] = 32'(clr1); o[3] = 32'(slot1);
      o[4] = 32'(hdr1); o[5] = 32'(pu1); o[6] = 32'(fs1);
    end
  endtask

  task automatic check_idle(input int d, input string tag);
    logic [31:0] o[7];
    sample(d, o);
    for (int i = 0; i < 7; i++)
      chk($sformatf("d%0d %s out%0d", d, tag, i), o[i], 32'd0);
  endtask

  // Checks ncyc cycles of one frame starting at frame cycle 0; leaves en low
  // from cycle drop_at onward.
  task automatic run_frame(input int d, input int is_run, input int bank,
                           input int ncyc, input int drop_at);
    int s, h, rw;
    logic [31:0] o[7];
    s  = (d == 0) ? 4 : 2;
    h  = (d == 0) ? 10 : 2;
    rw = s * 2 * h;
    for (int c = 0; c < ncyc; c++) begin
      if (c == drop_at) begin
        if (d == 0) en0 = 1'b0; else en1 = 1'b0;
      end
      sample(d, o);
      chk($sformatf("d%0d c%0d bank_sel", d, c),  o[0], 32'(bank));
      chk($sformatf("d%0d c%0d bank2_sel", d, c), o[1], 32'(bank));
      chk($sformatf("d%0d c%0d mem_clr", d, c),   o[2], 32'(c >= rw));
      chk($sformatf("d%0d c%0d slot", d, c),      o[3], (c < rw) ? 32'(c / (2 * h)) : 32'd0);
      chk($sformatf("d%0d c%0d header", d, c),    o[4], (c < rw) ? 32'((c % (2 * h)) >= h) : 32'd0);
      chk($sformatf("d%0d c%0d primeup", d, c),   o[5], 32'(is_run));
      chk($sformatf("d%0d c%0d frame_start", d, c), o[6], 32'(c == 0));
      @(negedge clk);
    end
  endtask

  initial begin
    rst0 = 1'b0; rst1 = 1'b0; en0 = 1'b0; en1 = 1'b0;
    repeat (2) @(negedge clk);
    check_idle(0, "reset");
    check_idle(1, "reset");
    rst0 = 1'b1; rst1 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_idle(0, "idle en0");
      check_idle(1, "idle en0");
    end

    // Default build: fill, two run frames, then en dropped mid-frame.
    en0 = 1'b1;
    @(negedge clk);
    run_frame(0, 0, 0, 84, -1);
    run_frame(0, 1, 0, 84, -1);
    run_frame(0, 1, 1, 84, -1);
    run_frame(0, 1, 0, 84, 30);
    repeat (3) begin
      check_idle(0, "after drop");
      @(negedge clk);
    end

    // Asynchronous reset at cycle 45 of a bank-1 run frame.
    en0 = 1'b1;
    @(negedge clk);
    run_frame(0, 0, 0, 84, -1);
    run_frame(0, 1, 0, 84, -1);
    run_frame(0, 1, 1, 45, -1);
    #2 rst0 = 1'b0;
    #1 check_idle(0, "async rst");
    @(negedge clk);
    check_idle(0, "rst held");
    rst0 = 1'b1;
    @(negedge clk);
    run_frame(0, 0, 0, 84, -1);
    run_frame(0, 1, 0, 84, 0);
    check_idle(0, "end d0");

    // Small build: F = 10, bank toggles each run frame.
    en1 = 1'b1;
    @(negedge clk);
    run_frame(1, 0, 0, 10, -1);
    run_frame(1, 1, 0, 10, -1);
    run_frame(1, 1, 1, 10, -1);
    run_frame(1, 1, 0, 10, 5);
    repeat (2) begin
      check_idle(1, "after drop");
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/output_frame_ctrl.md
OUTPUT_FRAME_CTRL -- requirements
Module: output_frame_ctrl

Interface
REQ-001 Parameter SLOTS, default 4: slots per output bank; SHALL be a power of two, 2 to 16.
REQ-002 Parameter HALF_CYC, default 10: clk cycles per header half and per payload half of one slot; SHALL be 2 to 64.
REQ-003 clk  input  1  the single clock; all logic SHALL be rising-edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 en  input  1  run request; sampled only where REQ-014/REQ-020 state.
REQ-006 bank_sel  output  1  write-bank select: 0 means the switch writes bank 0 and clears bank 1.
REQ-007 bank2_sel  output  1  read-bank select: 0 means bank 1 is read.
REQ-008 mem_clr  output  1  clear strobe, one slot cleared per asserted cycle.
REQ-009 running2_slot  output  $clog2(SLOTS)  slot index currently being read.
REQ-010 header2_present  output  1  0 selects the header half, 1 selects the payload half.
REQ-011 primeup  output  1  read data valid (drives sys_status[1]).
REQ-012 frame_start  output  1  one-cycle pulse in the first cycle of every frame.

Function
REQ-013 States: IDLE, FILL, RUN; one frame = F = SLOTS*2*HALF_CYC + SLOTS cycles, numbered 0..F-1 by a frame counter.
REQ-014 IDLE: counters held at 0, all outputs at reset values; en=1 sampled in IDLE -> FILL next cycle, with that cycle as frame cycle 0.
REQ-015 Frame timing: cycles 0..SLOTS*2*HALF_CYC-1 are the read window; the last SLOTS cycles are the guard window.
REQ-016 Read window: running2_slot = (cycle / (2*HALF_CYC)); header2_present = 0 for the first HALF_CYC cycles of each slot, 1 for the next HALF_CYC.
REQ-017 Guard window: running2_slot = 0, header2_present = 0; mem_clr = 1 for exactly these SLOTS cycles, so slots 0..SLOTS-1 of the read bank are cleared in order.
REQ-018 mem_clr SHALL never be 1 during the read window.
REQ-019 bank_sel and bank2_sel SHALL toggle together on the last cycle of every RUN frame, both becoming valid at frame cycle 0 of the next frame, and SHALL always be equal.
REQ-020 Frame boundary (last guard cycle): FILL -> RUN unconditionally; RUN with en=1 -> RUN (new frame); RUN with en=0 -> IDLE.
REQ-021 FILL: exactly one frame; bank_sel = bank2_sel = 0, primeup = 0; read-window counters run. Guard-window mem_clr clears bank 1 so the first RUN read sees no stale data; no bank toggle at the end of FILL.
REQ-022 primeup = 1 in every RUN cycle, 0 in IDLE and FILL.
REQ-023 en changes mid-frame SHALL have no effect until the frame boundary; a frame is never truncated.
REQ-024 frame_start = 1 at frame cycle 0 of every FILL and RUN frame, 0 otherwise.
REQ-025 All outputs SHALL be registered, with no combinational path from en to any output.
REQ-026 Counters wrap only at frame boundaries; running2_slot SHALL never exceed SLOTS-1.

Reset
REQ-027 rst=0 SHALL asynchronously force IDLE, frame counter 0, and all outputs to 0 (bank_sel, bank2_sel, mem_clr, running2_slot, header2_present, primeup, frame_start), including mid-frame.
REQ-028 After rst release, the block SHALL stay in IDLE until en=1 is sampled on a rising edge.

Verification
REQ-029 Defaults, reset, then en=1 held -> frame_start at cycle 0; primeup=0 for 84 cycles; primeup=1 from cycle 84; bank_sel=0 in FILL and the first RUN frame; bank_sel=1 from cycle 168.
REQ-030 RUN frame with defaults -> header2_present pattern is 10 zeros then 10 ones, repeated 4 times; running2_slot is 0,1,2,3 in 20-cycle steps; mem_clr=1 at cycles 80-83 only.
REQ-031 en dropped at frame cycle 30 of a RUN frame -> frame completes through cycle 83, including 4 mem_clr cycles; IDLE follows with all outputs 0.
REQ-032 rst asserted at frame cycle 45 of a RUN frame with bank_sel=1 -> all outputs 0 in the same cycle without waiting for a clock edge; with en=1 after release, a FILL frame restarts with bank_sel=0.
REQ-033 SLOTS=2, HALF_CYC=2 -> F=10; running2_slot is 0,0,0,0,1,1,1,1,0,0; mem_clr is high only at cycles 8-9; the bank toggles on every RUN frame.
REQ-034 Assertions on every cycle: bank_sel==bank2_sel, mem_clr implies the guard window, and running2_slot<SLOTS.
